reg_file_sweep: RTL and testbench



---
 rtl/reg_file_sweep.sv | 122 ++++++++++++
 tb/tb_reg_file_sweep.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sweep.sv
// DEPTH x WIDTH register file: one write port, two tri-stated read ports, hardware clear sweep.
// Latency: reads are combinational; writes land on the next clk edge; a sweep takes DEPTH cycles.
// Backpressure: none; writes issued while sweeping are discarded and flagged by a one-cycle wr_drop.
// Optional write-through forwarding in IDLE is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sweep #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  Din,
  input  logic [ADDR_W-1:0] raA,
  input  logic [ADDR_W-1:0] raB,
  input  logic              oeA,
  input  logic              oeB,
  output logic [WIDTH-1:0]  DA,
  output logic [WIDTH-1:0]  DB,
  input  logic              clr,
  output logic              busy,
  output logic              wr_drop
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              wr_drop_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              wr_en_d;
  logic [WIDTH-1:0]  rd_a_d;
  logic [WIDTH-1:0]  rd_b_d;

  // A write is accepted only in IDLE and only to an existing entry.
  always_comb begin
    wr_en_d = 1'b0;
    if (ld && ({1'b0, wa} < DEPTH_X) && (state_q == IDLE)) begin
      wr_en_d = 1'b1;
    end
  end

  // Read muxes: unpopulated addresses read as zero, optional forwarding of the in-flight write.
  always_comb begin
    rd_a_d = '0;
    rd_b_d = '0;
    if ({1'b0, raA} < DEPTH_X) begin
      rd_a_d = mem_q[raA];
    end
    if ({1'b0, raB} < DEPTH_X) begin
      rd_b_d = mem_q[raB];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_en_d && (raA == wa)) begin
      rd_a_d = Din;
    end
    if (wr_en_d && (raB == wa)) begin
      rd_b_d = Din;
    end
`else
`endif
  end

  assign DA      = oeA ? rd_a_d : {WIDTH{1'bz}};
  assign DB      = oeB ? rd_b_d : {WIDTH{1'bz}};
  assign busy    = busy_q;
  assign wr_drop = wr_drop_q;

  // Sweep FSM and storage: IDLE takes writes and clr, SWEEP zeroes one entry per edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en_d) begin
            mem_q[wa] <= Din;
          end
          if (clr) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
        end
        SWEEP: begin
          mem_q[ptr_q] <= '0;
          // Any write attempt during the sweep, including its last edge, is reported.
          wr_drop_q    <= ld;
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sweep.sv
// Scoreboard bench for reg_file_sweep: a default 8-entry instance plus a 6-entry instance.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares them.
// Both instances share every input so the 6-entry build sees identical traffic.
module tb_reg_file_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ld;
  logic        clr;
  logic        oea;
  logic        oeb;
  logic [2:0]  wa;
  logic [2:0]  raa;
  logic [2:0]  rab;
  logic [15:0] din;

  wire [15:0] da;
  wire [15:0] db;
  wire [15:0] da6;
  wire [15:0] db6;
  wire        busy;
  wire        wr_drop;
  wire        busy6;
  wire        wr_drop6;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file_sweep #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) u_dut (
    .clk(clk), .reset(reset), .ld(ld), .wa(wa), .Din(din),
    .raA(raa), .raB(rab), .oeA(oea), .oeB(oeb),
    .DA(da), .DB(db), .clr(clr), .busy(busy), .wr_drop(wr_drop)
  );

  reg_file_sweep #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) u_d6 (
    .clk(clk), .reset(reset), .ld(ld), .wa(wa), .Din(din),
    .raA(raa), .raB(rab), .oeA(oea), .oeB(oeb),
    .DA(da6), .DB(db6), .clr(clr), .busy(busy6), .wr_drop(wr_drop6)
  );

  localparam int S_DA    = 0;
  localparam int S_DB    = 1;
  localparam int S_BUSY  = 2;
  localparam int S_DROP  = 3;
  localparam int S_DAZ   = 4;
  localparam int S_DBZ   = 5;
  localparam int S_DA6   = 6;
  localparam int S_DB6   = 7;
  localparam int S_BUSY6 = 8;
  localparam int S_DROP6 = 9;

  typedef struct {
    string       nm;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input int sel, input logic [15:0] v);
    exp_t e;
    e.nm  = nm;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are settled by the falling edge, compare everything queued this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    logic        ok;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = '0;
      ok  = 1'b0;
      case (e.sel)
        S_DA:    act = da;
        S_DB:    act = db;
        S_BUSY:  act = {15'b0, busy};
        S_DROP:  act = {15'b0, wr_drop};
        S_DA6:   act = da6;
        S_DB6:   act = db6;
        S_BUSY6: act = {15'b0, busy6};
        S_DROP6: act = {15'b0, wr_drop6};
        S_DAZ: begin
          act = da;
          ok  = (da === 16'hzzzz);
        end
        S_DBZ: begin
          act = db;
          ok  = (db === 16'hzzzz);
        end
        default: act = 16'hdead;
      endcase
      if (e.sel != S_DAZ && e.sel != S_DBZ) begin
        ok = (act === e.exp);
      end
      n_tests++;
      if (!ok) begin
        n_fail++;
        if (e.sel == S_DAZ || e.sel == S_DBZ)
          $display("FAIL %s: got %h, required zzzz", e.nm, act);
        else
          $display("FAIL %s: got %h, required %h", e.nm, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ld = 1'b0; clr = 1'b0; wa = '0; din = '0;
    raa = '0; rab = '0; oea = 1'b1; oeb = 1'b0;
    #2 reset = 1'b0;
    step();

    // Reset state and tri-state with reset held low.
    chk("rst_da", S_DA, 16'h0000);
    chk("rst_db_z", S_DBZ, 16'h0000);
    chk("rst_busy", S_BUSY, 16'h0);
    chk("rst_drop", S_DROP, 16'h0);
    step();

    // Release reset, inputs held: nothing changes.
    reset = 1'b1;
    step();
    chk("rel_da", S_DA, 16'h0000);
    chk("rel_db_z", S_DBZ, 16'h0000);
    chk("rel_busy", S_BUSY, 16'h0);
    chk("rel_drop", S_DROP, 16'h0);
    step();

    // Writes to 1, 2, 7.
    ld = 1'b1; wa = 3'd1; din = 16'hAAAA; step();
    wa = 3'd2; din = 16'h5555; step();
    wa = 3'd7; din = 16'hC3C3; step();
    ld = 1'b0;

    raa = 3'd1; rab = 3'd7; oea = 1'b1; oeb = 1'b1;
    chk("dual_da", S_DA, 16'hAAAA);
    chk("dual_db", S_DB, 16'hC3C3);
    step();
    oea = 1'b0;
    chk("oea_off_z", S_DAZ, 16'h0000);
    chk("oea_off_db", S_DB, 16'hC3C3);
    step();

    // Same entry on both ports.
    oea = 1'b1; raa = 3'd2; rab = 3'd2;
    chk("same_da", S_DA, 16'h5555);
    chk("same_db", S_DB, 16'h5555);
    chk("d6_same_da", S_DA6, 16'h5555);
    step();

    // Out-of-range read on the 6-entry build; write to 7 was ignored there.
    raa = 3'd7; rab = 3'd1;
    chk("d6_oor_da", S_DA6, 16'h0000);
    chk("d6_other_db", S_DB6, 16'hAAAA);
    chk("d8_addr7", S_DA, 16'hC3C3);
    chk("d6_oor_nodrop", S_DROP6, 16'h0);
    step();

    // Write-through visibility before the edge.
    ld = 1'b1; wa = 3'd5; din = 16'h0F0F; raa = 3'd5; rab = 3'd5;
    chk("byp_da", S_DA, BYP ? 16'h0F0F : 16'h0000);
    chk("byp_db", S_DB, BYP ? 16'h0F0F : 16'h0000);
    step();
    ld = 1'b0;
    chk("post_wr_da", S_DA, 16'h0F0F);
    step();

    // Sweep timing: fill with FFFF, one-cycle clr.
    for (int i = 0; i < 8; i++) begin
      ld = 1'b1; wa = 3'(i); din = 16'hFFFF; step();
    end
    ld = 1'b0; clr = 1'b1;
    chk("pre_sweep_busy", S_BUSY, 16'h0);
    step();
    clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      raa = 3'(k);
      rab = (k == 0) ? 3'd7 : 3'(k - 1);
      chk("sweep_busy", S_BUSY, 16'h1);
      chk("sweep_head", S_DA, 16'hFFFF);
      chk("sweep_done", S_DB, (k == 0) ? 16'hFFFF : 16'h0000);
      chk("sweep_busy6", S_BUSY6, (k < 6) ? 16'h1 : 16'h0);
      chk("sweep_nodrop", S_DROP, 16'h0);
      step();
    end
    raa = 3'd0; rab = 3'd7;
    chk("sweep_end_busy", S_BUSY, 16'h0);
    chk("sweep_end_e0", S_DA, 16'h0000);
    chk("sweep_end_e7", S_DB, 16'h0000);
    step();

    // Collisions: dropped writes, clr ignored mid-sweep, final-edge drop.
    clr = 1'b1; step();
    clr = 1'b0;
    chk("col_busy1", S_BUSY, 16'h1);
    step();
    ld = 1'b1; wa = 3'd3; din = 16'h1234;
    chk("col_drop_pre", S_DROP, 16'h0);
    step();
    ld = 1'b0; clr = 1'b1;
    chk("col_drop", S_DROP, 16'h1);
    chk("col_drop6", S_DROP6, 16'h1);
    step();
    clr = 1'b0;
    chk("col_drop_single", S_DROP, 16'h0);
    chk("col_busy4", S_BUSY, 16'h1);
    step();
    ld = 1'b1; wa = 3'd1; din = 16'h1234;
    step();
    chk("b2b_drop1", S_DROP, 16'h1);
    step();
    ld = 1'b0;
    chk("b2b_drop2", S_DROP, 16'h1);
    chk("d6_final_drop", S_DROP6, 16'h1);
    chk("col_busy7", S_BUSY, 16'h1);
    chk("col_busy6_off", S_BUSY6, 16'h0);
    step();
    ld = 1'b1; wa = 3'd1; din = 16'h1234;
    chk("col_busy8", S_BUSY, 16'h1);
    chk("col_drop8", S_DROP, 16'h0);
    step();
    ld = 1'b0; raa = 3'd3; rab = 3'd1;
    chk("col_busy_off", S_BUSY, 16'h0);
    chk("final_edge_drop", S_DROP, 16'h1);
    chk("col_e3", S_DA, 16'h0000);
    chk("col_e1", S_DB, 16'h0000);
    step();
    chk("col_drop_clear", S_DROP, 16'h0);
    step();

    // clr and write on the same edge: write lands, then sweep clears it.
    clr = 1'b1; ld = 1'b1; wa = 3'd0; din = 16'hBEEF; raa = 3'd0;
    chk("clrwr_pre", S_DA, BYP ? 16'hBEEF : 16'h0000);
    step();
    clr = 1'b0; ld = 1'b0;
    chk("clrwr_e0", S_DA, 16'hBEEF);
    chk("clrwr_busy", S_BUSY, 16'h1);
    step();
    chk("clrwr_cleared", S_DA, 16'h0000);
    step();
    for (int i = 0; i < 6; i++) step();
    chk("clrwr_idle", S_BUSY, 16'h0);
    step();

    // Reset in the middle of a sweep.
    for (int i = 0; i < 8; i++) begin
      ld = 1'b1; wa = 3'(i); din = 16'hFFFF; step();
    end
    ld = 1'b0; clr = 1'b1; step();
    clr = 1'b0;
    step(); step(); step();
    reset = 1'b0; raa = 3'd4; rab = 3'd7;
    chk("mid_rst_busy", S_BUSY, 16'h0);
    chk("mid_rst_drop", S_DROP, 16'h0);
    chk("mid_rst_e4", S_DA, 16'h0000);
    chk("mid_rst_e7", S_DB, 16'h0000);
    step();
    raa = 3'd5; rab = 3'd6;
    chk("mid_rst_e5", S_DA, 16'h0000);
    chk("mid_rst_e6", S_DB, 16'h0000);
    step();
    reset = 1'b1; raa = 3'd0; rab = 3'd3;
    chk("post_rst_busy", S_BUSY, 16'h0);
    chk("post_rst_e0", S_DA, 16'h0000);
    chk("post_rst_e3", S_DB, 16'h0000);
    step();
    chk("post_rst_still_idle", S_BUSY, 16'h0);
    step();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
